// File: rtl/temp_1wire_pkg.sv
// temp_1wire_pkg: shared types and constants for the 1-wire temperature scheduler.
package temp_1wire_pkg;
   typedef enum logic [2:0] {IDLE, KICK, WAIT_DONE, CHECK, REPORT, FAULT, DONE_ST} state_t;
   localparam logic [7:0] CRC8_POLY_R = 8'h8C;
   localparam int SCRATCH_BYTES = 9;
   localparam int TEMP_LSB_BYTE = 0;
   localparam int TEMP_MSB_BYTE = 1;
   localparam int CRC_BYTE = 8;
   localparam int DATA_W = 8 * SCRATCH_BYTES;
endpackage

// File: rtl/crc8_1wire.sv
// crc8_1wire: bit-serial Dallas CRC-8 (reflected 0x8C, init 0), one data bit per enabled cycle, LSB first.
module crc8_1wire
   import temp_1wire_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output logic [7:0] crc
);
   always_ff @(posedge clk)
      if (rst || clr) crc <= '0;
      else if (en) crc <= (crc >> 1) ^ ((crc[0] ^ din) ? CRC8_POLY_R : 8'h00);
endmodule

// File: rtl/temp_1wire_sched.sv
// temp_1wire_sched: periodic/single-shot measurement scheduler and scratchpad checker for the 1-wire engine.
// Define TEMP_SCHED_CRC_EN to validate the scratchpad CRC-8 before publishing.
module temp_1wire_sched
   import temp_1wire_pkg::*;
#(
   parameter int FCLK       = 125,
   parameter int PERIOD_MS  = 1000,
   parameter int TIMEOUT_MS = 1000,
   parameter int RST_CYC    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              start,
   output logic              sens_rst,
   input  logic              sens_done,
   input  logic [DATA_W-1:0] sens_data,
   output logic              busy,
   output logic              temp_valid,
   output logic [15:0]       temp_value,
   output logic              crc_err,
   output logic              timeout_err,
   output logic [7:0]        err_cnt
);
   localparam int MS_CYC = FCLK * 1000;
   localparam int MW = $clog2(MS_CYC + 1);
   localparam int PW = $clog2(PERIOD_MS + 1);
   localparam int TW = $clog2(TIMEOUT_MS + 1);
   localparam int KW = $clog2(RST_CYC + 1);
   state_t state;
   logic [MW-1:0] ms_cnt;
   logic [PW-1:0] per_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [KW-1:0] kick_cnt;
   logic tick, go, crc_ok;
   assign tick = ms_cnt == MW'(MS_CYC - 1);
   assign go = (start && !busy) || (enable && per_cnt == '0);
`ifdef TEMP_SCHED_CRC_EN
   logic [DATA_W-1:0] data;
   logic [5:0] bit_idx;
   logic [7:0] crc;
   crc8_1wire u_crc (
      .clk (clk),
      .rst (rst),
      .clr (state == WAIT_DONE),
      .en  (state == CHECK),
      .din (data[bit_idx]),
      .crc (crc)
   );
   assign crc_ok = crc == data[8*CRC_BYTE +: 8];
`else
   logic [15:0] data;
   logic unused_hi;
   assign unused_hi = ^sens_data[DATA_W-1:16];
   assign crc_ok = 1'b1;
`endif
   always_ff @(posedge clk)
      if (rst) ms_cnt <= '0;
      else ms_cnt <= tick ? '0 : ms_cnt + 1'b1;
   always_ff @(posedge clk)
      if (rst) begin
         state       <= IDLE;
         sens_rst    <= 1'b1;
         busy        <= 1'b0;
         temp_valid  <= 1'b0;
         temp_value  <= '0;
         crc_err     <= 1'b0;
         timeout_err <= 1'b0;
         err_cnt     <= '0;
         per_cnt     <= '0;
         tmo_cnt     <= '0;
         kick_cnt    <= '0;
         data        <= '0;
`ifdef TEMP_SCHED_CRC_EN
         bit_idx     <= '0;
`endif
      end else begin
         temp_valid  <= 1'b0;
         crc_err     <= 1'b0;
         timeout_err <= 1'b0;
         busy        <= (state != IDLE) || go;
         if (tick && per_cnt != '0) per_cnt <= per_cnt - 1'b1;
         case (state)
            IDLE:
               if (go) begin
                  state    <= KICK;
                  kick_cnt <= '0;
               end
            KICK: begin
               per_cnt  <= PW'(PERIOD_MS);
               tmo_cnt  <= '0;
               kick_cnt <= kick_cnt + 1'b1;
               if (kick_cnt == KW'(RST_CYC - 1)) begin
                  state    <= WAIT_DONE;
                  sens_rst <= 1'b0;
               end
            end
            WAIT_DONE:
               if (sens_done) begin
                  data  <= sens_data[$bits(data)-1:0];
`ifdef TEMP_SCHED_CRC_EN
                  state   <= CHECK;
                  bit_idx <= '0;
`else
                  state <= REPORT;
`endif
               end else if (tick) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (tmo_cnt == TW'(TIMEOUT_MS - 1)) begin
                     state       <= FAULT;
                     timeout_err <= 1'b1;
                  end
               end
`ifdef TEMP_SCHED_CRC_EN
            CHECK: begin
               bit_idx <= bit_idx + 1'b1;
               if (bit_idx == 6'd63) state <= REPORT;
            end
`endif
            REPORT:
               if (crc_ok) begin
                  temp_value <= {data[8*TEMP_MSB_BYTE +: 8], data[8*TEMP_LSB_BYTE +: 8]};
                  temp_valid <= 1'b1;
                  state      <= DONE_ST;
               end else begin
                  crc_err <= 1'b1;
                  state   <= FAULT;
               end
            FAULT: begin
               sens_rst <= 1'b1;
               if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
               state    <= IDLE;
            end
            DONE_ST: begin
               sens_rst <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_temp_1wire_sched.sv
// tb_temp_1wire_sched: directed self-checking bench for temp_1wire_sched with a simple engine model.
module tb_temp_1wire_sched;
   localparam int FCLK = 1, PERIOD_MS = 3, TIMEOUT_MS = 2, RST_CYC = 4;
`ifdef TEMP_SCHED_CRC_EN
   localparam bit CRC = 1'b1;
   localparam int LAT = 66;
`else
   localparam bit CRC = 1'b0;
   localparam int LAT = 2;
`endif
   localparam logic [71:0] GOOD = 72'h1C_10_0C_FF_7F_46_4B_05_50;
   localparam logic [71:0] BAD  = 72'h1D_10_0C_FF_7F_46_4B_05_50;
   logic clk = 1'b0, rst = 1'b1, enable = 1'b0, start = 1'b0;
   logic sens_rst, sens_done = 1'b0;
   logic [71:0] sens_data = '0;
   logic busy, temp_valid, crc_err, timeout_err;
   logic [15:0] temp_value;
   logic [7:0] err_cnt;
   int n_run = 0, n_fail = 0;
   int cyc = 0, k_cyc = 0, s_cyc = 0, n_valid = 0, n_crc = 0, n_tmo = 0;
   logic done_d = 1'b0;
   logic eng_on = 1'b1;
   int eng_dly = 5, ecnt = 0;
   temp_1wire_sched #(.FCLK(FCLK), .PERIOD_MS(PERIOD_MS), .TIMEOUT_MS(TIMEOUT_MS), .RST_CYC(RST_CYC)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .start       (start),
      .sens_rst    (sens_rst),
      .sens_done   (sens_done),
      .sens_data   (sens_data),
      .busy        (busy),
      .temp_valid  (temp_valid),
      .temp_value  (temp_value),
      .crc_err     (crc_err),
      .timeout_err (timeout_err),
      .err_cnt     (err_cnt)
   );
   always #5 clk = ~clk;
   // Engine model: raises done a fixed delay after release, drops it when held in reset.
   always @(negedge clk)
      if (sens_rst !== 1'b0) begin
         sens_done = 1'b0;
         ecnt = 0;
      end else if (eng_on) begin
         if (ecnt >= eng_dly) sens_done = 1'b1;
         else ecnt++;
      end
   always @(posedge clk) begin
      cyc++;
      if (sens_done && !done_d) k_cyc = cyc;
      done_d = sens_done;
      if (temp_valid === 1'b1) begin n_valid++; s_cyc = cyc; end
      if (crc_err === 1'b1) begin n_crc++; s_cyc = cyc; end
      if (timeout_err === 1'b1) n_tmo++;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask
   task automatic pulse_start(output int n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (sens_rst && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask
   task automatic wait_strobe(output int c);
      c = 0;
      while (!(temp_valid || crc_err || timeout_err) && c < 5000) begin
         @(negedge clk);
         c++;
      end
      if (c >= 5000) chk("strobe_wait", {31'd0, temp_valid | crc_err | timeout_err}, 1);
   endtask
   task automatic wait_idle();
      int c = 0;
      while (busy && c < 5000) begin
         @(negedge clk);
         c++;
      end
      if (c >= 5000) chk("idle_wait", {31'd0, busy}, 0);
      @(negedge clk);
   endtask
   initial begin
      int n, c, v0, e0;
      sens_data = GOOD;
      repeat (3) @(negedge clk);
      chk("rst_sens_rst", {31'd0, sens_rst}, 1);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_valid", {31'd0, temp_valid}, 0);
      chk("rst_value", {16'd0, temp_value}, 0);
      chk("rst_crc_err", {31'd0, crc_err}, 0);
      chk("rst_tmo_err", {31'd0, timeout_err}, 0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 0);
      rst = 1'b0;
      @(negedge clk);
      // free-run: first start right after enable
      enable = 1'b1;
      wait_strobe(c);
      enable = 1'b0;
      chk("good_valid", {31'd0, temp_valid}, 1);
      chk("good_value", {16'd0, temp_value}, 32'h0550);
      chk("good_err_cnt", {24'd0, err_cnt}, 0);
      @(negedge clk);
      chk("good_latency", s_cyc - k_cyc, LAT);
      chk("sens_rst_after", {31'd0, sens_rst}, 1);
      chk("busy_hold", {31'd0, busy}, 1);
      @(negedge clk);
      chk("busy_low", {31'd0, busy}, 0);
      repeat (3) @(negedge clk);
      // bad CRC byte
      sens_data = BAD;
      v0 = n_valid;
      pulse_start(n);
      chk("release_delay", n, RST_CYC + 1);
      wait_strobe(c);
      chk("bad_crc_err", {31'd0, crc_err}, CRC ? 1 : 0);
      chk("bad_valid", {31'd0, temp_valid}, CRC ? 0 : 1);
      chk("bad_value", {16'd0, temp_value}, 32'h0550);
      @(negedge clk);
      chk("bad_err_cnt", {24'd0, err_cnt}, CRC ? 1 : 0);
      wait_idle();
      // missing sensor
      eng_on = 1'b0;
      e0 = n_tmo;
      pulse_start(n);
      wait_strobe(c);
      chk("tmo_strobe", {31'd0, timeout_err}, 1);
      chk("tmo_window", {31'd0, c >= 1000 * FCLK * (TIMEOUT_MS - 1) && c <= 1000 * FCLK * TIMEOUT_MS + 2}, 1);
      @(negedge clk);
      chk("tmo_sens_rst", {31'd0, sens_rst}, 1);
      chk("tmo_err_cnt", {24'd0, err_cnt}, CRC ? 2 : 1);
      chk("tmo_count", n_tmo - e0, 1);
      wait_idle();
      // single shot with a second start while busy
      eng_on = 1'b1;
      sens_data = GOOD;
      v0 = n_valid + n_crc;
      pulse_start(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (200) @(negedge clk);
      chk("one_shot_count", n_valid + n_crc - v0, 1);
      chk("one_shot_idle", {31'd0, busy}, 0);
      // reset mid-measurement
      pulse_start(n);
      c = 0;
      while (CRC && !sens_done && c < 100) begin
         @(negedge clk);
         c++;
      end
      repeat (2) @(negedge clk);
      v0 = n_valid + n_crc;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_sens_rst", {31'd0, sens_rst}, 1);
      chk("mid_rst_busy", {31'd0, busy}, 0);
      chk("mid_rst_value", {16'd0, temp_value}, 0);
      chk("mid_rst_err_cnt", {24'd0, err_cnt}, 0);
      repeat (100) @(negedge clk);
      chk("mid_rst_no_strobe", n_valid + n_crc - v0, 0);
      pulse_start(n);
      wait_strobe(c);
      chk("after_rst_valid", {31'd0, temp_valid}, 1);
      chk("after_rst_value", {16'd0, temp_value}, 32'h0550);
      wait_idle();
      // error counter saturation
      sens_data = BAD;
      for (int i = 0; i < 300; i++) begin
         pulse_start(n);
         wait_idle();
      end
      chk("err_cnt_sat", {24'd0, err_cnt}, CRC ? 255 : 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
